mem_bank_responder: RTL and testbench

//  Responder end of the user-side memory bank port (req/ce/w/a/tag/d/be -> ready/valid/q/qtag).

---
 rtl/mem_bank_responder.sv | 217 +++++++++++++++++++++
 tb/tb_mem_bank_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_responder.sv
// mem_bank_responder
//   On-chip stand-in for one user-side memory bank. Grants the initiator a
//   fixed number of cycles after req rises, accepts one read or write per
//   cycle while ready is high, and returns read data with a fixed latency.
//   An optional periodic stall drops ready for one cycle after every
//   STALL_PERIOD accepts, so initiators can be exercised deterministically.
//
// Ports
//   clk, rst       clock, async active-low reset
//   req            initiator wants the bank
//   ce, w          command strobe, 1 = write / 0 = read
//   a, tag         word address (low DEPTH_LOG2 bits used), command tag
//   d, be          write data and byte enables
//   ready          bank granted and accepting commands
//   valid, q, qtag read return: strobe, data, echoed tag (q/qtag hold)
//   wr_count       accepted writes (wraps)
//   rd_count       accepted reads (wraps)
//   proto_err      sticky, ce seen while req low
//
// Storage is split into byte lanes so byte enables map to independent
// per-lane write strobes. Storage is never reset.

// One byte lane of storage, synchronous read and write.
module mem_bank_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

module mem_bank_responder #(
  parameter int DATA_WIDTH    = 128,
  parameter int TAG_WIDTH     = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BE_WIDTH      = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2    = 10,
  parameter int LATENCY       = 4,   // >= 2
  parameter int GRANT_DELAY   = 2,   // >= 1
  parameter int STALL_PERIOD  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     ce,
  input  logic                     w,
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic [TAG_WIDTH-1:0]     tag,
  input  logic [DATA_WIDTH-1:0]    d,
  input  logic [BE_WIDTH-1:0]      be,
  output logic                     ready,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    q,
  output logic [TAG_WIDTH-1:0]     qtag,
  output logic [31:0]              wr_count,
  output logic [31:0]              rd_count,
  output logic                     proto_err
);

  // gcnt counts dwell cycles in WAIT; the IDLE->WAIT edge already spends one
  // of the GRANT_DELAY cycles, so WAIT lasts GRANT_DELAY-1 cycles.
  localparam int CW         = $clog2(GRANT_DELAY + 1);
  localparam int WAIT_LAST  = (GRANT_DELAY > 1) ? GRANT_DELAY - 2 : 0;
  localparam int SW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int STALL_LAST = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  state_t          state;
  logic [CW-1:0]   gcnt;
  logic [SW-1:0]   acc_cnt;
  logic            accept, wr_acc, rd_acc, stall_hit;
  logic [DEPTH_LOG2-1:0] mem_addr;

  assign accept   = ce & ready;
  assign wr_acc   = accept & w;
  assign rd_acc   = accept & ~w;
  assign mem_addr = a[DEPTH_LOG2-1:0];

  // Upper address bits alias onto the same storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^a[ADDRESS_WIDTH-1:DEPTH_LOG2];

  // The accept that completes a period drops ready for the next cycle.
  assign stall_hit = (STALL_PERIOD > 0) && accept && (acc_cnt == SW'(STALL_LAST));

  // Grant FSM with registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gcnt    <= '0;
      acc_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gcnt    <= '0;
          acc_cnt <= '0;
          ready   <= 1'b0;
          if (req) begin
            if (GRANT_DELAY == 1) begin
              state <= GRANT;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          acc_cnt <= '0;
          ready   <= 1'b0;
          if (!req) begin
            state <= IDLE;
          end else if (gcnt == CW'(WAIT_LAST)) begin
            state <= GRANT;
            ready <= 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        GRANT: begin
          if (!req) begin
            state   <= IDLE;
            ready   <= 1'b0;
            acc_cnt <= '0;
          end else if (stall_hit) begin
            ready   <= 1'b0;
            acc_cnt <= '0;
          end else begin
            ready <= 1'b1;
            if (accept) acc_cnt <= acc_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane storage; stage 0 of the read pipe is the lane read register.
  logic [BE_WIDTH-1:0][7:0] rd_bytes;
  logic [DATA_WIDTH-1:0]    rd_word;

  for (genvar k = 0; k < BE_WIDTH; k++) begin : g_lane
    mem_bank_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk   (clk),
      .we    (wr_acc & be[k]),
      .re    (rd_acc),
      .addr  (mem_addr),
      .wdata (d[8*k +: 8]),
      .rdata (rd_bytes[k])
    );
  end

  assign rd_word = rd_bytes;

  // Read pipeline: vld_pipe[0] is set on the accept edge, vld_pipe[LATENCY]
  // is the output strobe. Payload is not reset; only the valid bits are.
  logic [LATENCY:0]           vld_pipe;
  logic [TAG_WIDTH-1:0]       tag0;
  rsp_t [LATENCY-1:1]         rsp_pipe;

  always_ff @(posedge clk) begin
    if (rd_acc) tag0 <= tag;
    rsp_pipe[1] <= '{tag: tag0, data: rd_word};
    for (int k = 2; k < LATENCY; k++) rsp_pipe[k] <= rsp_pipe[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      q        <= '0;
      qtag     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:0], rd_acc};
      if (vld_pipe[LATENCY-1]) begin
        q    <= rsp_pipe[LATENCY-1].data;
        qtag <= rsp_pipe[LATENCY-1].tag;
      end
    end
  end

  assign valid = vld_pipe[LATENCY];

  // Counters register on the accept edge, visible the cycle after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr_acc) wr_count <= wr_count + 32'd1;
      if (rd_acc) rd_count <= rd_count + 32'd1;
      if (ce && !req) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bank_responder.sv
module tb_mem_bank_responder;

  localparam int LAT = 4;
  localparam int GD  = 2;

  logic         clk, rst, req, ce, w;
  logic [31:0]  a;
  logic [1:0]   tag;
  logic [127:0] d;
  logic [15:0]  be;

  logic         ready0, valid0, perr0, ready1, valid1, perr1;
  logic [127:0] q0, q1;
  logic [1:0]   qt0, qt1;
  logic [31:0]  wc0, rc0, wc1, rc1;

  mem_bank_responder #(.LATENCY(LAT), .GRANT_DELAY(GD), .STALL_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .req(req), .ce(ce), .w(w), .a(a), .tag(tag), .d(d), .be(be),
    .ready(ready0), .valid(valid0), .q(q0), .qtag(qt0),
    .wr_count(wc0), .rd_count(rc0), .proto_err(perr0));

  mem_bank_responder #(.LATENCY(LAT), .GRANT_DELAY(GD), .STALL_PERIOD(3)) dut_s (
    .clk(clk), .rst(rst), .req(req), .ce(ce), .w(w), .a(a), .tag(tag), .d(d), .be(be),
    .ready(ready1), .valid(valid1), .q(q1), .qtag(qt1),
    .wr_count(wc1), .rd_count(rc1), .proto_err(perr1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;
  int vcount0 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int           inst;
    int           due;
    logic [127:0] data;
    logic [1:0]   tag;
  } rd_t;

  rd_t          pend[$];
  logic [127:0] m_mem [2][1024];
  int           m_run[2], m_acc[2];
  logic         m_ready[2], m_valid[2], m_perr[2];
  logic [127:0] m_q[2];
  logic [1:0]   m_qtag[2];
  logic [31:0]  m_wr[2], m_rd[2];
  int           cyc = 0;

  function automatic int spd(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  task automatic model_step();
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_acc[i] = 0; m_ready[i] = 0; m_valid[i] = 0;
        m_q[i] = '0; m_qtag[i] = '0; m_wr[i] = '0; m_rd[i] = '0; m_perr[i] = 0;
      end
      pend.delete();
      return;
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic acc, stall;
      int idx;
      rd_t e;
      acc = ce && m_ready[i];
      idx = int'(a[9:0]);
      if (ce && !req) m_perr[i] = 1'b1;
      if (acc && w) begin
        for (int k = 0; k < 16; k++)
          if (be[k]) m_mem[i][idx][8*k +: 8] = d[8*k +: 8];
        m_wr[i] = m_wr[i] + 1;
      end
      if (acc && !w) begin
        e.inst = i; e.due = cyc + LAT; e.data = m_mem[i][idx]; e.tag = tag;
        pend.push_back(e);
        m_rd[i] = m_rd[i] + 1;
      end
      m_valid[i] = 1'b0;
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].inst == i) begin
          if (pend[j].due == cyc) begin
            m_valid[i] = 1'b1;
            m_q[i] = pend[j].data;
            m_qtag[i] = pend[j].tag;
            pend.delete(j);
          end
          break;
        end
      end
      // Granted once req has been seen high on GD consecutive edges.
      if (req) begin
        if (m_run[i] < GD) m_run[i]++;
      end else begin
        m_run[i] = 0;
      end
      stall = 1'b0;
      if (m_run[i] >= GD) begin
        if (acc) begin
          m_acc[i]++;
          stall = (spd(i) > 0) && (m_acc[i] % spd(i) == 0);
        end
      end else begin
        m_acc[i] = 0;
      end
      m_ready[i] = (m_run[i] >= GD) && !stall;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (valid0) vcount0++;
      if (chk_en) begin
        chk("ready0", ready0, m_ready[0]); chk("valid0", valid0, m_valid[0]);
        chk("q0", q0, m_q[0]);             chk("qtag0", qt0, m_qtag[0]);
        chk("wr_count0", wc0, m_wr[0]);    chk("rd_count0", rc0, m_rd[0]);
        chk("proto_err0", perr0, m_perr[0]);
        chk("ready1", ready1, m_ready[1]); chk("valid1", valid1, m_valid[1]);
        chk("q1", q1, m_q[1]);             chk("qtag1", qt1, m_qtag[1]);
        chk("wr_count1", wc1, m_wr[1]);    chk("rd_count1", rc1, m_rd[1]);
        chk("proto_err1", perr1, m_perr[1]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                     input logic [15:0] bm, input logic [1:0] t);
    ce = 1'b1; w = wr; a = addr; d = data; be = bm; tag = t;
    tick();
    ce = 1'b0;
  endtask

  // Called just after a read's accept edge.
  task automatic wait_rd(input logic [127:0] eq, input logic [1:0] et, input string nm);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early"}, valid0, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, valid0, 1);
    chk({nm, "_q"}, q0, eq);
    chk({nm, "_qtag"}, qt0, et);
  endtask

  localparam logic [127:0] D5 = 128'hA5A5_0F0F_1234_5678_9ABC_DEF0_CAFE_F00D;

  initial begin
    int vb;
    logic [9:0] pat;
    rst = 1'b0; req = 1'b0; ce = 1'b0; w = 1'b0; a = '0; tag = '0; d = '0; be = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready0, 0); chk("rst_valid", valid0, 0); chk("rst_q", q0, 0);
    chk("rst_qtag", qt0, 0);     chk("rst_wr", wc0, 0);       chk("rst_rd", rc0, 0);
    chk("rst_perr", perr0, 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // grant timing
    req = 1'b1;
    @(posedge clk); @(negedge clk); chk("t1_ready_c1", ready0, 0);
    @(posedge clk); @(negedge clk); chk("t1_ready_c2", ready0, 1);
    req = 1'b0;
    @(posedge clk); @(negedge clk); chk("t1_ready_drop", ready0, 0);

    // prefill the low addresses used by random traffic (every other cycle)
    req = 1'b1; tick(); tick();
    for (int i = 0; i < 16; i++) begin
      cmd(1'b1, i, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 2'd0);
      tick();
    end

    cmd(1'b1, 32'd5, 128'h11223344, 16'hFFFF, 2'd0);
    cmd(1'b0, 32'd5, '0, '0, 2'd2);
    wait_rd(128'h11223344, 2'd2, "t2");

    cmd(1'b1, 32'd7, {128{1'b1}}, 16'hFFFF, 2'd0);
    cmd(1'b1, 32'd7, '0, 16'h0001, 2'd0);
    cmd(1'b0, 32'd7, '0, '0, 2'd1);
    wait_rd({{15{8'hFF}}, 8'h00}, 2'd1, "t3");

    vb = vcount0;
    ce = 1'b1; w = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = i; tag = 2'(i);
      tick();
    end
    ce = 1'b0;
    repeat (6) tick();
    chk("t4_valid_cycles", vcount0 - vb, 8);
    chk("t4_rd_count", rc0, 10);

    cmd(1'b1, 32'h400, D5, 16'hFFFF, 2'd0);
    cmd(1'b0, 32'h0, '0, '0, 2'd3);
    wait_rd(D5, 2'd3, "t5_alias");
    req = 1'b0; tick();
    ce = 1'b1; w = 1'b1; a = 32'd9; tick(); ce = 1'b0;
    @(negedge clk);
    chk("t5_perr", perr0, 1);
    chk("t5_wr_count", wc0, 20);
    chk("t5_rd_count", rc0, 11);

    // periodic stall on the STALL_PERIOD=3 instance
    req = 1'b1; tick(); tick();
    ce = 1'b1; w = 1'b0; pat = '0;
    for (int i = 0; i < 10; i++) begin
      a = i % 16; tag = 2'(i);
      @(negedge clk);
      pat[9-i] = ready1;
      @(posedge clk); #1;
    end
    ce = 1'b0;
    chk("t6_stall_pattern", pat, 10'b1110111011);

    for (int n = 0; n < 1500; n++) begin
      req = ($urandom_range(0, 19) != 0);
      ce  = ($urandom_range(0, 9) < 6);
      w   = $urandom_range(0, 1);
      a   = $urandom & 32'hFFFF_FC0F;
      tag = 2'($urandom);
      d   = {$urandom, $urandom, $urandom, $urandom};
      be  = 16'($urandom);
      tick();
    end

    // reset with reads in flight
    ce = 1'b0; req = 1'b1; tick(); tick();
    ce = 1'b1; w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = i; tag = 2'(i + 1);
      tick();
    end
    ce = 1'b0; rst = 1'b0; req = 1'b0;
    vb = vcount0;
    @(negedge clk);
    chk("t7_ready", ready0, 0); chk("t7_valid", valid0, 0); chk("t7_q", q0, 0);
    chk("t7_qtag", qt0, 0);     chk("t7_wr", wc0, 0);       chk("t7_rd", rc0, 0);
    chk("t7_perr", perr0, 0);
    tick(); tick();
    rst = 1'b1;
    repeat (8) tick();
    chk("t7_no_valid", vcount0 - vb, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
